// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_flex buffering primitive.
package fifo_pkg;

  typedef enum logic {
    FIFO_DROP      = 1'b0,
    FIFO_OVERWRITE = 1'b1
  } fifo_policy_e;

  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: one write port, one registered read port, no reset.
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read-before-write: a same-address read returns the old entry.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_flex.sv
// Synchronous FIFO with wrap-bit pointers, occupancy thresholds, a drop or
// overwrite overflow policy, sticky error flags and a saturating drop counter.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1,
  parameter int OVERWRITE  = 0,
  parameter int DROP_CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       clear_flags,
  input  logic                       write_en,
  input  logic [WIDTH-1:0]           write_data,
  input  logic                       read_en,
  output logic [WIDTH-1:0]           read_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [fifo_aw(DEPTH):0]    count,
  output logic                       overflow,
  output logic                       underflow,
  output logic [DROP_CNT_W-1:0]      drop_count
);

  localparam int AW = fifo_aw(DEPTH);
  localparam int CW = AW + 1;
  localparam fifo_policy_e POLICY = (OVERWRITE != 0) ? FIFO_OVERWRITE : FIFO_DROP;

  localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]         AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0]         AE_C     = CW'(AE_THRESH);
  localparam logic [AW:0]           PTR_ONE  = 1;
  localparam logic [CW-1:0]         CNT_ONE  = 1;
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = 1;

  logic [AW:0]       w_ptr, r_ptr;
  logic [CW-1:0]     cnt;
  logic              ra, wa, ovf_evt, udf_evt, ow_evt, mem_we, adv_rd;
  logic              have_data;
  logic [WIDTH-1:0]  mem_q;

  assign count        = cnt;
  assign full         = (cnt == DEPTH_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);

  // Handshake: a read is accepted when read_en is high and the FIFO is not
  // empty; its word appears on read_data with rd_valid high on the next cycle.
  // No bypass, so a write never satisfies a read in the same cycle.
  assign ra      = read_en && !empty && !flush;
  assign wa      = write_en && (!full || ra) && !flush;
  assign ovf_evt = write_en && full && !read_en && !flush;
  assign udf_evt = read_en && empty && !flush;
  assign ow_evt  = ovf_evt && (POLICY == FIFO_OVERWRITE);
  assign mem_we  = wa || ow_evt;
  assign adv_rd  = ra || ow_evt;

  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (w_ptr[AW-1:0]),
    .wdata (write_data),
    .re    (ra),
    .raddr (r_ptr[AW-1:0]),
    .rdata (mem_q)
  );

  // The storage has no reset, so read_data is masked to zero until a read lands.
  assign read_data = have_data ? mem_q : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      cnt       <= '0;
      rd_valid  <= 1'b0;
      have_data <= 1'b0;
    end else begin
      rd_valid <= ra;
      if (ra) have_data <= 1'b1;
      if (flush) begin
        w_ptr <= '0;
        r_ptr <= '0;
        cnt   <= '0;
      end else begin
        if (mem_we) w_ptr <= w_ptr + PTR_ONE;
        if (adv_rd) r_ptr <= r_ptr + PTR_ONE;
        if (wa && !ra)      cnt <= cnt + CNT_ONE;
        else if (ra && !wa) cnt <= cnt - CNT_ONE;
      end
    end
  end

  // A same-cycle event outranks clear_flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      drop_count <= '0;
    end else if (clear_flags) begin
      overflow   <= ovf_evt;
      underflow  <= udf_evt;
      drop_count <= ovf_evt ? DROP_ONE : '0;
    end else begin
      if (ovf_evt) overflow <= 1'b1;
      if (udf_evt) underflow <= 1'b1;
      if (ovf_evt && (drop_count != '1)) drop_count <= drop_count + DROP_ONE;
    end
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Scoreboard bench for fifo_flex: a drop-policy and an overwrite-policy instance share stimulus.
module tb_fifo_flex;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush, clear_flags, write_en, read_en;
  logic [31:0] write_data;

  logic [31:0] read_data_d, read_data_o;
  logic        rd_valid_d, rd_valid_o, full_d, full_o, empty_d, empty_o;
  logic        almost_full_d, almost_full_o, almost_empty_d, almost_empty_o;
  logic [3:0]  count_d, count_o;
  logic        overflow_d, overflow_o, underflow_d, underflow_o;
  logic [7:0]  drop_count_d, drop_count_o;

  logic [31:0] exp_d_q[$];
  logic [31:0] exp_o_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_flex #(.WIDTH(32), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .OVERWRITE(0), .DROP_CNT_W(8)) dut_d (
    .clk(clk), .reset(reset), .flush(flush), .clear_flags(clear_flags),
    .write_en(write_en), .write_data(write_data), .read_en(read_en),
    .read_data(read_data_d), .rd_valid(rd_valid_d), .full(full_d), .empty(empty_d),
    .almost_full(almost_full_d), .almost_empty(almost_empty_d), .count(count_d),
    .overflow(overflow_d), .underflow(underflow_d), .drop_count(drop_count_d)
  );

  fifo_flex #(.WIDTH(32), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .OVERWRITE(1), .DROP_CNT_W(8)) dut_o (
    .clk(clk), .reset(reset), .flush(flush), .clear_flags(clear_flags),
    .write_en(write_en), .write_data(write_data), .read_en(read_en),
    .read_data(read_data_o), .rd_valid(rd_valid_o), .full(full_o), .empty(empty_o),
    .almost_full(almost_full_o), .almost_empty(almost_empty_o), .count(count_o),
    .overflow(overflow_o), .underflow(underflow_o), .drop_count(drop_count_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every rd_valid pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && rd_valid_d) begin
      checks++;
      if (exp_d_q.size() == 0) begin
        errors++;
        $display("FAIL rd_drop: unexpected read_data %0h at %0t", read_data_d, $time);
      end else begin
        logic [31:0] e;
        e = exp_d_q.pop_front();
        if (read_data_d !== e) begin
          errors++;
          $display("FAIL rd_drop: got %0h expected %0h at %0t", read_data_d, e, $time);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && rd_valid_o) begin
      checks++;
      if (exp_o_q.size() == 0) begin
        errors++;
        $display("FAIL rd_ovw: unexpected read_data %0h at %0t", read_data_o, $time);
      end else begin
        logic [31:0] e;
        e = exp_o_q.pop_front();
        if (read_data_o !== e) begin
          errors++;
          $display("FAIL rd_ovw: got %0h expected %0h at %0t", read_data_o, e, $time);
        end
      end
    end
  end

  // One clock with the given inputs; returns #1 after the edge.
  task automatic step(input logic we, input logic [31:0] wd, input logic re,
                      input logic fl, input logic cf);
    write_en = we; write_data = wd; read_en = re; flush = fl; clear_flags = cf;
    @(posedge clk); #1;
    write_en = 1'b0; read_en = 1'b0; flush = 1'b0; clear_flags = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd2(input logic [31:0] e_d, input logic [31:0] e_o);
    exp_d_q.push_back(e_d);
    exp_o_q.push_back(e_o);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic fill_a;
    for (int i = 0; i < 8; i++) wr(32'hA0 + i);
  endtask

  task automatic chk_both(input string name, input logic [31:0] a_d, input logic [31:0] a_o,
                          input logic [31:0] exp);
    chk({name, "_drop"}, a_d, exp);
    chk({name, "_ovw"}, a_o, exp);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; clear_flags = 1'b0;
    write_en = 1'b0; read_en = 1'b0; write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_both("rst_count", count_d, count_o, 0);
    chk_both("rst_empty", empty_d, empty_o, 1);
    chk_both("rst_rdata", read_data_d, read_data_o, 0);
    chk_both("rst_drop", drop_count_d, drop_count_o, 0);
    reset = 1'b0;

    // Fill and drain
    for (int i = 0; i < 8; i++) begin
      wr(32'hA0 + i);
      chk_both("fill_count", count_d, count_o, i + 1);
      chk_both("fill_af", almost_full_d, almost_full_o, (i + 1 >= 6) ? 1 : 0);
      chk_both("fill_full", full_d, full_o, (i == 7) ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) begin
      rd2(32'hA0 + i, 32'hA0 + i);
      chk_both("drain_rv", rd_valid_d, rd_valid_o, 1);
      chk_both("drain_count", count_d, count_o, 7 - i);
      chk_both("drain_ae", almost_empty_d, almost_empty_o, (7 - i <= 1) ? 1 : 0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk_both("idle_rv", rd_valid_d, rd_valid_o, 0);
    chk_both("idle_hold", read_data_d, read_data_o, 32'hA7);
    chk_both("drain_empty", empty_d, empty_o, 1);

    // Wrap-around
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) wr(32'h50 + 8 * r + i);
      chk_both("wrap_count", count_d, count_o, 5);
      chk_both("wrap_full", full_d, full_o, 0);
      for (int i = 0; i < 5; i++) rd2(32'h50 + 8 * r + i, 32'h50 + 8 * r + i);
    end

    // Overflow by one word
    fill_a();
    wr(32'hFF);
    chk_both("drop_ovf", overflow_d, overflow_o, 1);
    chk_both("drop_cnt", drop_count_d, drop_count_o, 1);
    chk_both("drop_count", count_d, count_o, 8);
    for (int i = 0; i < 8; i++) rd2(32'hA0 + i, (i < 7) ? 32'hA1 + i : 32'hFF);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk_both("clr_ovf", overflow_d, overflow_o, 0);
    chk_both("clr_cnt", drop_count_d, drop_count_o, 0);

    // Overflow by two, then clear_flags colliding with a third
    fill_a();
    wr(32'hB0);
    wr(32'hB1);
    chk_both("ovw_cnt", drop_count_d, drop_count_o, 2);
    chk_both("ovw_count", count_d, count_o, 8);
    step(1'b1, 32'hB2, 1'b0, 1'b0, 1'b1);
    chk_both("clrwin_ovf", overflow_d, overflow_o, 1);
    chk_both("clrwin_cnt", drop_count_d, drop_count_o, 1);
    for (int i = 0; i < 8; i++) rd2(32'hA0 + i, (i < 5) ? 32'hA3 + i : 32'hB0 + (i - 5));
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Drop counter saturation, then flush keeps sticky flags
    fill_a();
    for (int i = 0; i < 260; i++) wr(32'h100 + i);
    chk_both("sat_cnt", drop_count_d, drop_count_o, 255);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk_both("flush_count", count_d, count_o, 0);
    chk_both("flush_ovf", overflow_d, overflow_o, 1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Full with simultaneous read and write
    fill_a();
    exp_d_q.push_back(32'hA0);
    exp_o_q.push_back(32'hA0);
    step(1'b1, 32'hC0, 1'b1, 1'b0, 1'b0);
    chk_both("frw_count", count_d, count_o, 8);
    chk_both("frw_ovf", overflow_d, overflow_o, 0);
    for (int i = 0; i < 8; i++) rd2((i < 7) ? 32'hA1 + i : 32'hC0, (i < 7) ? 32'hA1 + i : 32'hC0);

    // Empty with simultaneous read and write
    step(1'b1, 32'hD0, 1'b1, 1'b0, 1'b0);
    chk_both("erw_udf", underflow_d, underflow_o, 1);
    chk_both("erw_rv", rd_valid_d, rd_valid_o, 0);
    chk_both("erw_count", count_d, count_o, 1);
    rd2(32'hD0, 32'hD0);

    // Asynchronous reset mid-burst
    wr(32'h11);
    wr(32'h12);
    wr(32'h13);
    #3 reset = 1'b1;
    #1;
    chk_both("arst_count", count_d, count_o, 0);
    chk_both("arst_udf", underflow_d, underflow_o, 0);
    chk_both("arst_rdata", read_data_d, read_data_o, 0);
    chk_both("arst_empty", empty_d, empty_o, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Flush beats a same-cycle write; read_data is retained
    wr(32'hE5);
    wr(32'hE6);
    rd2(32'hE5, 32'hE5);
    step(1'b1, 32'hE0, 1'b0, 1'b1, 1'b0);
    chk_both("fl_count", count_d, count_o, 0);
    chk_both("fl_empty", empty_d, empty_o, 1);
    chk_both("fl_rdata", read_data_d, read_data_o, 32'hE5);
    wr(32'hE1);
    rd2(32'hE1, 32'hE1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    chk("leftover_drop", exp_d_q.size(), 0);
    chk("leftover_ovw", exp_o_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
